// File: rtl/hes_stream_decipher.sv
// hes_stream_decipher: byte-serial counter-mode decipher for the HES stream cipher.
//   Keystream byte = AES S-box(counter XOR key); plaintext = ciphertext XOR keystream.
//   Latency: 2 cycles from accepted input beat to data_out with ready_in held high; 1 byte/cycle.
//   Backpressure: ready_out drops only when both pipeline stages are full and downstream stalls.
//
// Ports:
//   clk, reset_n        clock (rising edge) / asynchronous reset, asserted high
//   valid_in, ready_out input handshake; new_message marks the first byte of a message
//   key, data_in        message key (sampled on accepted new_message beat), ciphertext byte
//   data_out, valid_out output plaintext and valid, completed when ready_in is high
//   counter_block       counter used for the byte currently on data_out
//   drop                one-cycle pulse per input byte discarded while no message is open
module hes_stream_decipher #(
  parameter logic [7:0] COUNTER_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       valid_in,
  output logic       ready_out,
  input  logic       new_message,
  input  logic [7:0] key,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  input  logic       ready_in,
  output logic [7:0] counter_block,
  output logic       drop
);

  // Standard AES forward S-box.
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] key_q, key_d;
  logic       drop_q, drop_d;

  logic       s1_valid_q, s1_valid_d;
  logic [7:0] s1_ct_q, s1_ct_d;
  logic [7:0] s1_idx_q, s1_idx_d;
  logic [7:0] s1_ctr_q, s1_ctr_d;

  logic       valid_out_q, valid_out_d;
  logic [7:0] data_out_q, data_out_d;
  logic [7:0] ctr_out_q, ctr_out_d;

  logic       accept;
  logic       advance;
  logic       take;       // accepted byte enters the pipeline
  logic [7:0] byte_ctr;
  logic [7:0] byte_key;

  assign ready_out = !(s1_valid_q && valid_out_q && !ready_in);
  assign accept    = valid_in && ready_out;
  assign advance   = !valid_out_q || ready_in;

  // FSM / counter / key next-state. A new_message beat uses the live key input
  // rather than key_q, since key_q only captures it on this same edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    drop_d   = 1'b0;
    take     = 1'b0;
    byte_ctr = cnt_q;
    byte_key = key_q;
    if (accept) begin
      if (new_message) begin
        state_d  = ACTIVE;
        key_d    = key;
        cnt_d    = COUNTER_INIT + 8'd1;
        byte_ctr = COUNTER_INIT;
        byte_key = key;
        take     = 1'b1;
      end else if (state_q == ACTIVE) begin
        cnt_d = cnt_q + 8'd1;
        take  = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  // Stage 1 also loads while empty even if stage 2 is stalled; that is what
  // lets ready_out stay high until both stages hold data.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_ct_d    = s1_ct_q;
    s1_idx_d   = s1_idx_q;
    s1_ctr_d   = s1_ctr_q;
    if (advance || !s1_valid_q) begin
      s1_valid_d = take;
      if (take) begin
        s1_ct_d  = data_in;
        s1_idx_d = byte_ctr ^ byte_key;
        s1_ctr_d = byte_ctr;
      end
    end
  end

  // Stage 2: S-box lookup and XOR; holds while the output beat is stalled.
  always_comb begin
    valid_out_d = valid_out_q;
    data_out_d  = data_out_q;
    ctr_out_d   = ctr_out_q;
    if (advance) begin
      valid_out_d = s1_valid_q;
      if (s1_valid_q) begin
        data_out_d = s1_ct_q ^ SBOX[s1_idx_q];
        ctr_out_d  = s1_ctr_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= COUNTER_INIT;
      key_q       <= 8'h00;
      drop_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_ct_q     <= 8'h00;
      s1_idx_q    <= 8'h00;
      s1_ctr_q    <= 8'h00;
      valid_out_q <= 1'b0;
      data_out_q  <= 8'h00;
      ctr_out_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      drop_q      <= drop_d;
      s1_valid_q  <= s1_valid_d;
      s1_ct_q     <= s1_ct_d;
      s1_idx_q    <= s1_idx_d;
      s1_ctr_q    <= s1_ctr_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      ctr_out_q   <= ctr_out_d;
    end
  end

  assign valid_out     = valid_out_q;
  assign data_out      = data_out_q;
  assign counter_block = ctr_out_q;
  assign drop          = drop_q;

endmodule

// File: tb/tb_hes_stream_decipher.sv
// Bench for hes_stream_decipher: directed scenarios plus a random phase, all
// checked by an in-bench model that predicts plaintext from the cipher rules
// (S-box derived arithmetically from GF(2^8) inversion plus the affine map).
module tb_hes_stream_decipher;
  localparam logic [7:0] CI = 8'h00;

  logic       clk;
  logic       reset_n;
  logic       valid_in;
  logic       ready_out;
  logic       new_message;
  logic [7:0] key;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       ready_in;
  logic [7:0] counter_block;
  logic       drop;

  hes_stream_decipher #(.COUNTER_INIT(CI)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_out(ready_out),
    .new_message(new_message), .key(key), .data_in(data_in), .data_out(data_out),
    .valid_out(valid_out), .ready_in(ready_in), .counter_block(counter_block), .drop(drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  dat;
    logic [7:0]  ctr;
    logic [31:0] cyc;
  } ent_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rmode    = 0;
  int   drop_cnt = 0;
  int   ro_low   = 0;
  logic [7:0] sbox_tab [256];
  ent_t exp_q [$];
  ent_t log_q [$];

  // model state (written only by the compare process)
  logic       m_active = 1'b0;
  logic [7:0] m_cnt    = CI;
  logic [7:0] m_key    = 8'h00;
  logic       m_drop_pend = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  // Compare process: checks outputs every cycle, then applies this cycle's
  // input beat to the model.
  always @(negedge clk) begin
    ent_t e;
    logic drop_next;
    logic [7:0] c;
    if (reset_n) begin
      exp_q.delete();
      m_active = 1'b0; m_cnt = CI; m_key = 8'h00; m_drop_pend = 1'b0;
      check("rst_valid_out", valid_out, 0);
      check("rst_ready_out", ready_out, 1);
      check("rst_drop", drop, 0);
      check("rst_data_out", data_out, 0);
    end else begin
      check("drop", drop, m_drop_pend);
      if (drop) drop_cnt++;
      check("ready_out", ready_out, !(exp_q.size() == 2 && !ready_in));
      if (!ready_out) ro_low++;
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          check("data_out", data_out, exp_q[0].dat);
          check("counter_block", counter_block, exp_q[0].ctr);
          if (ready_in) begin
            e = exp_q.pop_front();
            log_q.push_back('{dat: data_out, ctr: counter_block, cyc: 32'(cyc) - e.cyc});
          end
        end
      end
      drop_next = 1'b0;
      if (valid_in && ready_out) begin
        if (new_message) begin
          m_active = 1'b1; m_key = key; m_cnt = CI + 8'd1;
          exp_q.push_back('{dat: data_in ^ sbox_tab[CI ^ key], ctr: CI, cyc: 32'(cyc)});
        end else if (m_active) begin
          c = m_cnt;
          exp_q.push_back('{dat: data_in ^ sbox_tab[c ^ m_key], ctr: c, cyc: 32'(cyc)});
          m_cnt = m_cnt + 8'd1;
        end else begin
          drop_next = 1'b1;
        end
      end
      m_drop_pend = drop_next;
    end
  end

  // ready_in driver: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random
  initial begin
    int ph;
    ph = 0;
    ready_in = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: ready_in = 1'b1;
        1: begin ready_in = (ph == 0); ph = (ph + 1) % 3; end
        default: ready_in = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send(input logic nm, input logic [7:0] k, input logic [7:0] d);
    logic acc;
    acc = 1'b0;
    valid_in = 1'b1; new_message = nm; key = k; data_in = d;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = ready_out;
      @(posedge clk); #1;
    end
    if (!acc) check("send_timeout", 0, 1);
    valid_in = 1'b0; new_message = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain_empty", exp_q.size(), 0);
    idle(2);
  endtask

  task automatic do_reset();
    reset_n = 1'b1;
    valid_in = 1'b0; new_message = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
  endtask

  initial begin
    int b, d0, r0;
    logic [7:0] k, ct;
    logic [7:0] pt [258];
    logic [7:0] ctv [4];

    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
    check("model_sbox_00", sbox_tab[8'h00], 8'h63);
    check("model_sbox_11", sbox_tab[8'h11], 8'h82);
    check("model_sbox_53", sbox_tab[8'h53], 8'hed);

    reset_n = 1'b1; valid_in = 1'b0; new_message = 1'b0; key = 8'h00; data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid_out", valid_out, 0);
    check("reset_data_out", data_out, 8'h00);
    check("reset_counter_block", counter_block, 8'h00);
    check("reset_ready_out", ready_out, 1);
    check("reset_drop", drop, 0);
    reset_n = 1'b0;

    // single message, literal expectations
    ctv[0] = 8'h82; ctv[1] = 8'hca; ctv[2] = 8'h7d; ctv[3] = 8'hc9;
    b = log_q.size();
    send(1'b1, 8'h11, ctv[0]);
    for (int i = 1; i < 4; i++) send(1'b0, 8'hee, ctv[i]);
    drain();
    check("single_count", log_q.size() - b, 4);
    for (int i = 0; i < 4 && b + i < log_q.size(); i++) begin
      check("single_data", log_q[b+i].dat, 8'h00);
      check("single_ctr", log_q[b+i].ctr, i);
      check("single_latency", log_q[b+i].cyc, 2);
    end

    // round trip, then the same stream under 1,0,0 backpressure
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      rmode = pass;
      r0 = ro_low;
      b = log_q.size();
      for (int i = 0; i < 10; i++) begin
        ct = 8'(i) ^ sbox_tab[(CI + 8'(i)) ^ 8'h11];
        send(i == 0, 8'h11, ct);
      end
      drain();
      check("rt_count", log_q.size() - b, 10);
      for (int i = 0; i < 10 && b + i < log_q.size(); i++) begin
        check("rt_plain", log_q[b+i].dat, i);
        check("rt_ctr", log_q[b+i].ctr, i);
      end
      if (pass == 1) check("bp_ready_low_seen", ro_low > r0, 1);
    end
    rmode = 0;

    // counter wrap across 258 bytes
    do_reset();
    k = 8'($urandom);
    b = log_q.size();
    for (int i = 0; i < 258; i++) begin
      pt[i] = 8'($urandom);
      send(i == 0, k, pt[i] ^ sbox_tab[(CI + 8'(i)) ^ k]);
    end
    drain();
    check("wrap_count", log_q.size() - b, 258);
    if (log_q.size() - b == 258) begin
      for (int i = 0; i < 258; i++) check("wrap_plain", log_q[b+i].dat, pt[i]);
      check("wrap_ctr_ff", log_q[b+255].ctr, 8'hff);
      check("wrap_ctr_00", log_q[b+256].ctr, 8'h00);
      check("wrap_ctr_01", log_q[b+257].ctr, 8'h01);
    end

    // drop then restart
    do_reset();
    d0 = drop_cnt;
    b = log_q.size();
    send(1'b0, 8'h11, 8'h55);
    idle(3);
    check("drop_pulses", drop_cnt - d0, 1);
    check("drop_no_output", log_q.size() - b, 0);
    send(1'b1, 8'h11, 8'h82);
    drain();
    check("restart_count", log_q.size() - b, 1);
    if (log_q.size() > b) check("restart_data", log_q[b].dat, 8'h00);

    // asynchronous reset with two bytes in flight
    do_reset();
    send(1'b1, 8'h3c, 8'ha5);
    send(1'b0, 8'h00, 8'h5a);
    check("async_pre_valid", valid_out, 1);
    #2 reset_n = 1'b1;
    #1;
    check("async_valid_fall", valid_out, 0);
    check("async_data_clear", data_out, 8'h00);
    @(posedge clk); #1 reset_n = 1'b0;
    d0 = drop_cnt;
    b = log_q.size();
    send(1'b0, 8'h3c, 8'h77);
    idle(3);
    check("async_drop_after", drop_cnt - d0, 1);
    check("async_no_output", log_q.size() - b, 0);

    // random traffic with random backpressure and message restarts
    do_reset();
    rmode = 2;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        valid_in = 1'b0;
        new_message = 1'($urandom_range(0, 1));
        key = 8'($urandom);
        @(posedge clk); #1;
        new_message = 1'b0;
      end else begin
        send($urandom_range(0, 19) == 0, 8'($urandom), 8'($urandom));
      end
    end
    drain();
    rmode = 0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
